// File: rtl/l1_trigger_pkg.sv
// l1_trigger_pkg
// Shared definitions for the L1 trigger scaler: the period-control state
// encoding and the default parameter values used by l1_trigger_scaler.
// No ports (package only).
package l1_trigger_pkg;

    localparam int DEF_NBEAMS        = 2;
    localparam int DEF_COUNT_WIDTH   = 32;
    localparam int DEF_PERIOD_CLOCKS = 375000000;
    localparam int DEF_HOLDOFF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } scalerState_t;

endpackage

// File: rtl/l1_beam_counter.sv
// l1_beam_counter
// One beam's trigger path: holdoff qualification, the registered qualified
// trigger output and the live event counter for the current period.
// Optional macro L1_SCALER_SATURATE_EN: live count saturates at all-ones
// instead of wrapping.
// Ports:
//   aclk, reset_i       clock, async active-high reset
//   trig_i, mask_i      raw trigger bit and disable bit for this beam
//   holdoff_i           holdoff length loaded after each accepted trigger
//   clear_i             restart the live count this cycle
//   countEn_i           accepted triggers are counted this cycle
//   trigger_o           accepted trigger, one cycle late
//   count_o             live count
module l1_beam_counter #(
    parameter int COUNT_WIDTH   = 32,
    parameter int HOLDOFF_WIDTH = 5
) (
    input  logic                     aclk,
    input  logic                     reset_i,
    input  logic                     trig_i,
    input  logic                     mask_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic                     clear_i,
    input  logic                     countEn_i,
    output logic                     trigger_o,
    output logic [COUNT_WIDTH-1:0]   count_o
);

    logic [HOLDOFF_WIDTH-1:0] holdoffCnt_q, holdoffCnt_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d, countInc;
    logic                     trigger_q;
    logic                     accept;

    // Qualify the raw trigger and run the holdoff down. A holdoff of zero
    // reloads zero, so every asserted cycle is accepted.
    always_comb begin
        accept       = trig_i & ~mask_i & (holdoffCnt_q == '0);
        holdoffCnt_d = holdoffCnt_q;
        if (accept) begin
            holdoffCnt_d = holdoff_i;
        end else if (holdoffCnt_q != '0) begin
            holdoffCnt_d = holdoffCnt_q - HOLDOFF_WIDTH'(1);
        end
    end

    // Live count next state. A clear with counting enabled is the
    // continuous-mode rollover: the new period starts at 1 if this beam
    // accepts in the rollover cycle itself.
    always_comb begin
`ifdef L1_SCALER_SATURATE_EN
        countInc = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
`else
        countInc = count_q + COUNT_WIDTH'(1);
`endif
        count_d = count_q;
        if (clear_i) begin
            count_d = (countEn_i && accept) ? COUNT_WIDTH'(1) : '0;
        end else if (countEn_i && accept) begin
            count_d = countInc;
        end
    end

    // Per-beam state registers.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            holdoffCnt_q <= '0;
            count_q      <= '0;
            trigger_q    <= 1'b0;
        end else begin
            holdoffCnt_q <= holdoffCnt_d;
            count_q      <= count_d;
            trigger_q    <= accept;
        end
    end

    assign trigger_o = trigger_q;
    assign count_o   = count_q;

endmodule

// File: rtl/l1_trigger_scaler.sv
// l1_trigger_scaler
// Counts holdoff-qualified beam triggers over fixed periods of PERIOD_CLOCKS
// counting cycles and copies the counts into a readable snapshot bank at the
// end of each period (one-shot or continuous).
// Optional macro L1_SCALER_SATURATE_EN: live counts saturate (see
// l1_beam_counter); otherwise they wrap.
// Ports:
//   aclk, reset_i          clock, async active-high reset
//   trig_i, mask_i         raw triggers, per-beam disable
//   holdoff_i              holdoff cycles after each accepted trigger
//   start_i, stop_i        begin/restart a period, abort counting
//   mode_i                 0 one-shot, 1 continuous
//   rd_beam_i, rd_dat_o    snapshot readout (1-cycle latency)
//   trigger_o              qualified triggers
//   busy_o, done_o, seq_o  status, snapshot pulse, snapshot sequence number
module l1_trigger_scaler
    import l1_trigger_pkg::*;
#(
    parameter int NBEAMS        = DEF_NBEAMS,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int PERIOD_CLOCKS = DEF_PERIOD_CLOCKS,
    parameter int HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH
) (
    input  logic                     aclk,
    input  logic                     reset_i,
    input  logic [NBEAMS-1:0]        trig_i,
    input  logic [NBEAMS-1:0]        mask_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     mode_i,
    input  logic [7:0]               rd_beam_i,
    output logic [COUNT_WIDTH-1:0]   rd_dat_o,
    output logic [NBEAMS-1:0]        trigger_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [7:0]               seq_o
);

    localparam int TIMER_WIDTH = $clog2(PERIOD_CLOCKS);
    localparam logic [TIMER_WIDTH-1:0] TIMER_RELOAD = TIMER_WIDTH'(PERIOD_CLOCKS - 1);

    scalerState_t                         state_q, state_d;
    logic [TIMER_WIDTH-1:0]               timer_q, timer_d;
    logic                                 mode_q, mode_d;
    logic [7:0]                           seq_q;
    logic [NBEAMS-1:0][COUNT_WIDTH-1:0]   snapshot_q;
    logic [NBEAMS-1:0][COUNT_WIDTH-1:0]   liveCount;
    logic [COUNT_WIDTH-1:0]               rdDat_q, rdDat_d;
    logic                                 clearCnt;
    logic                                 countEn;
    logic                                 snapWr;

    for (genvar g = 0; g < NBEAMS; g++) begin : gBeam
        l1_beam_counter #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .HOLDOFF_WIDTH(HOLDOFF_WIDTH)
        ) uBeam (
            .aclk     (aclk),
            .reset_i  (reset_i),
            .trig_i   (trig_i[g]),
            .mask_i   (mask_i[g]),
            .holdoff_i(holdoff_i),
            .clear_i  (clearCnt),
            .countEn_i(countEn),
            .trigger_o(trigger_o[g]),
            .count_o  (liveCount[g])
        );
    end

    // Period control. The timer runs PERIOD_CLOCKS-1 down to 0 across the
    // COUNT cycles, so a period is exactly PERIOD_CLOCKS counting cycles.
    // In LATCH the snapshot is always written first; stop/start seen there
    // only decide where we go afterwards. A start from LATCH clears counts
    // outright, while a continuous rollover keeps the LATCH-cycle trigger.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        mode_d   = mode_q;
        clearCnt = 1'b0;
        countEn  = 1'b0;
        snapWr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop_i && start_i) begin
                    clearCnt = 1'b1;
                    timer_d  = TIMER_RELOAD;
                    mode_d   = mode_i;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    clearCnt = 1'b1;
                    timer_d  = TIMER_RELOAD;
                    mode_d   = mode_i;
                end else begin
                    countEn = 1'b1;
                    if (timer_q == '0) begin
                        state_d = LATCH;
                    end else begin
                        timer_d = timer_q - TIMER_WIDTH'(1);
                    end
                end
            end
            LATCH: begin
                snapWr = 1'b1;
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    clearCnt = 1'b1;
                    timer_d  = TIMER_RELOAD;
                    mode_d   = mode_i;
                    state_d  = COUNT;
                end else if (mode_q) begin
                    clearCnt = 1'b1;
                    countEn  = 1'b1;
                    timer_d  = TIMER_RELOAD;
                    mode_d   = mode_i;
                    state_d  = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot readout mux; indices beyond the last beam read as zero.
    always_comb begin
        rdDat_d = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (rd_beam_i == 8'(b)) begin
                rdDat_d = snapshot_q[b];
            end
        end
    end

    // Control registers, snapshot bank and the registered readout.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            mode_q     <= 1'b0;
            seq_q      <= 8'd0;
            snapshot_q <= '0;
            rdDat_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            rdDat_q <= rdDat_d;
            if (snapWr) begin
                snapshot_q <= liveCount;
                seq_q      <= seq_q + 8'd1;
            end
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = snapWr;
    assign seq_o    = seq_q;
    assign rd_dat_o = rdDat_q;

endmodule

// File: tb/tb_l1_trigger_scaler.sv
// tb_l1_trigger_scaler
// Directed bench for l1_trigger_scaler with NBEAMS=4, PERIOD_CLOCKS=16,
// COUNT_WIDTH=3 (so the overflow case is reachable). Expected values are
// hand-computed; the overflow expectation follows L1_SCALER_SATURATE_EN.
module tb_l1_trigger_scaler;

    localparam int NB     = 4;
    localparam int CW     = 3;
    localparam int PERIOD = 16;
    localparam int HW     = 5;
`ifdef L1_SCALER_SATURATE_EN
    localparam int OVF_EXPECT = 7;
`else
    localparam int OVF_EXPECT = 0;
`endif

    logic          aclk;
    logic          reset_i;
    logic [NB-1:0] trig_i;
    logic [NB-1:0] mask_i;
    logic [HW-1:0] holdoff_i;
    logic          start_i;
    logic          stop_i;
    logic          mode_i;
    logic [7:0]    rd_beam_i;
    logic [CW-1:0] rd_dat_o;
    logic [NB-1:0] trigger_o;
    logic          busy_o;
    logic          done_o;
    logic [7:0]    seq_o;

    int checkCount = 0;
    int failCount  = 0;
    int doneCount  = 0;

    l1_trigger_scaler #(
        .NBEAMS       (NB),
        .COUNT_WIDTH  (CW),
        .PERIOD_CLOCKS(PERIOD),
        .HOLDOFF_WIDTH(HW)
    ) dut (
        .aclk     (aclk),
        .reset_i  (reset_i),
        .trig_i   (trig_i),
        .mask_i   (mask_i),
        .holdoff_i(holdoff_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .mode_i   (mode_i),
        .rd_beam_i(rd_beam_i),
        .rd_dat_o (rd_dat_o),
        .trigger_o(trigger_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .seq_o    (seq_o)
    );

    // Free-running 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case the design wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge, noting done pulses.
    task automatic tick();
        @(posedge aclk);
        #1;
        if (done_o === 1'b1) doneCount++;
    endtask

    task automatic applyStimulus(input logic [NB-1:0] trig, input logic start,
                                 input logic stop);
        trig_i  = trig;
        start_i = start;
        stop_i  = stop;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    task automatic readSnap(input logic [7:0] beam, output logic [31:0] val);
        rd_beam_i = beam;
        tick();
        val = 32'(rd_dat_o);
    endtask

    // Clock until done_o is seen, bounded; returns the number of clocks.
    task automatic waitDone(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done_o !== 1'b1 && n < limit);
        if (done_o !== 1'b1) checkOutput("doneTimeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [31:0] val;
        int          n;
        logic        mask2Seen;

        reset_i   = 1'b1;
        trig_i    = '0;
        mask_i    = '0;
        holdoff_i = 5'd3;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        mode_i    = 1'b0;
        rd_beam_i = 8'd0;
        tick();
        tick();
        checkOutput("rstTrigger", 32'(trigger_o), 32'(0));
        checkOutput("rstBusy",    32'(busy_o),    32'(0));
        checkOutput("rstDone",    32'(done_o),    32'(0));
        checkOutput("rstSeq",     32'(seq_o),     32'(0));
        checkOutput("rstRdDat",   32'(rd_dat_o),  32'(0));
        reset_i = 1'b0;
        tick();

        // One-shot period, beam 0 held high: accepts every 4th cycle -> 4.
        $display("[TB] one-shot period");
        doneCount = 0;
        mode_i = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("osBusy", 32'(busy_o), 32'(1));
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("osTrigAccept", 32'(trigger_o), 32'(4'b0001));
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("osTrigHoldoff", 32'(trigger_o), 32'(0));
        for (int i = 0; i < 14; i++) applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("osLatchDone", 32'(done_o), 32'(1));
        checkOutput("osLatchBusy", 32'(busy_o), 32'(1));
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("osIdleBusy", 32'(busy_o), 32'(0));
        checkOutput("osIdleDone", 32'(done_o), 32'(0));
        checkOutput("osSeq", 32'(seq_o), 32'(1));
        checkOutput("osDoneCount", 32'(doneCount), 32'(1));
        readSnap(8'd0, val);
        checkOutput("osSnap0", val, 32'(4));
        readSnap(8'd1, val);
        checkOutput("osSnap1", val, 32'(0));

        // Continuous mode; beam 1 pulsed in the LATCH cycle belongs to period 2.
        $display("[TB] continuous mode");
        doneCount = 0;
        mode_i = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        waitDone(40, n);
        checkOutput("contFirstLen", 32'(n), 32'(16));
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("contLatchTrig", 32'(trigger_o), 32'(4'b0010));
        checkOutput("contReloadBusy", 32'(busy_o), 32'(1));
        trig_i = '0;
        waitDone(40, n);
        checkOutput("contPeriodLen", 32'(n + 1), 32'(17));
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("contStillBusy", 32'(busy_o), 32'(1));
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("contStopBusy", 32'(busy_o), 32'(0));
        checkOutput("contSeq", 32'(seq_o), 32'(3));
        checkOutput("contDoneCount", 32'(doneCount), 32'(2));
        readSnap(8'd1, val);
        checkOutput("contSnap1", val, 32'(1));
        readSnap(8'd0, val);
        checkOutput("contSnap0", val, 32'(0));

        // Stop and start together mid-period: abort, nothing written.
        $display("[TB] stop with start");
        doneCount = 0;
        mode_i = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("stopBusy", 32'(busy_o), 32'(0));
        trig_i = '0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("stopDoneCount", 32'(doneCount), 32'(0));
        checkOutput("stopSeq", 32'(seq_o), 32'(3));
        readSnap(8'd1, val);
        checkOutput("stopSnap1", val, 32'(1));

        // Beam 2 masked while held high; beam 0 counts normally.
        $display("[TB] masked beam");
        mask_i = 4'b0100;
        mask2Seen = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b0101, 1'b0, 1'b0);
            if (trigger_o[2] !== 1'b0) mask2Seen = 1'b1;
        end
        checkOutput("maskDone", 32'(done_o), 32'(1));
        checkOutput("maskTrigger2", 32'(mask2Seen), 32'(0));
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("maskSeq", 32'(seq_o), 32'(4));
        readSnap(8'd2, val);
        checkOutput("maskSnap2", val, 32'(0));
        readSnap(8'd0, val);
        checkOutput("maskSnap0", val, 32'(4));
        readSnap(8'd4, val);
        checkOutput("rdOutOfRange", val, 32'(0));
        mask_i = '0;

        // Holdoff 0 on beam 3: 16 accepts overflow a 3-bit counter.
        $display("[TB] counter overflow");
        holdoff_i = 5'd0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("ovfTrigger", 32'(trigger_o), 32'(4'b1000));
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("ovfSeq", 32'(seq_o), 32'(5));
        readSnap(8'd3, val);
        checkOutput("ovfSnap3", val, 32'(OVF_EXPECT));
        readSnap(8'd0, val);
        checkOutput("ovfSnap0", val, 32'(0));
        for (int i = 0; i < 5; i++) tick();
        readSnap(8'd3, val);
        checkOutput("snapHold", val, 32'(OVF_EXPECT));

        // Reset in the middle of a period.
        $display("[TB] reset mid-period");
        holdoff_i = 5'd3;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("preRstTrigger", 32'(trigger_o), 32'(4'b0001));
        checkOutput("preRstBusy", 32'(busy_o), 32'(1));
        doneCount = 0;
        reset_i = 1'b1;
        #1;
        checkOutput("midRstTrigger", 32'(trigger_o), 32'(0));
        checkOutput("midRstBusy",    32'(busy_o),    32'(0));
        checkOutput("midRstDone",    32'(done_o),    32'(0));
        checkOutput("midRstSeq",     32'(seq_o),     32'(0));
        checkOutput("midRstRdDat",   32'(rd_dat_o),  32'(0));
        tick();
        reset_i = 1'b0;
        trig_i  = '0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("postRstDoneCount", 32'(doneCount), 32'(0));
        checkOutput("postRstBusy", 32'(busy_o), 32'(0));
        readSnap(8'd5, val);
        checkOutput("postRstRd5", val, 32'(0));
        readSnap(8'd3, val);
        checkOutput("postRstSnap3", val, 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/l1_trigger_scaler.md
L1_TRIGGER_SCALER -- requirements
Module: l1_trigger_scaler

Interface
REQ-001 Parameter NBEAMS, default 2, number of beam trigger inputs (1..256).
REQ-002 Parameter COUNT_WIDTH, default 32, width of each per-beam count.
REQ-003 Parameter PERIOD_CLOCKS, default 375000000, aclk cycles per counting period (>=2).
REQ-004 Parameter HOLDOFF_WIDTH, default 5, width of the programmable holdoff.
REQ-005 aclk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 trig_i  in  NBEAMS  raw per-beam trigger bits from the beamformer.
REQ-008 mask_i  in  NBEAMS  1 = beam disabled (neither counted nor forwarded).
REQ-009 holdoff_i  in  HOLDOFF_WIDTH  holdoff length in cycles after each accepted trigger.
REQ-010 start_i  in  1  single-cycle pulse: clear counts and begin a period.
REQ-011 stop_i  in  1  single-cycle pulse: abort counting.
REQ-012 mode_i  in  1  0 = one-shot, 1 = continuous; sampled at each period start.
REQ-013 rd_beam_i  in  8  beam index for snapshot readout.
REQ-014 rd_dat_o  out  COUNT_WIDTH  snapshot count of the selected beam.
REQ-015 trigger_o  out  NBEAMS  holdoff-qualified triggers.
REQ-016 busy_o  out  1  high in COUNT and LATCH.
REQ-017 done_o  out  1  one-cycle pulse when a snapshot is written.
REQ-018 seq_o  out  8  snapshot sequence number; wraps 255 -> 0.

Function
REQ-019 An accepted trigger on beam b SHALL be trig_i[b] & ~mask_i[b] & (holdoff_cnt[b]==0); on acceptance holdoff_cnt[b] loads holdoff_i, otherwise it decrements to 0; holdoff_i=0 accepts every asserted cycle.
REQ-020 trigger_o[b] SHALL be the accepted trigger registered with 1-cycle latency, active in every FSM state.
REQ-021 The FSM SHALL have states IDLE, COUNT and LATCH.
REQ-022 In IDLE, start_i SHALL clear all live counts, load the timer with PERIOD_CLOCKS-1, latch mode_i, and enter COUNT.
REQ-023 In COUNT, the timer SHALL decrement each cycle, accepted triggers SHALL increment live counts, and the FSM SHALL enter LATCH when the timer reaches 0.
REQ-024 The period SHALL therefore be exactly PERIOD_CLOCKS counting cycles (COUNT cycles only).
REQ-025 In LATCH, live counts SHALL be copied to the snapshot bank, done_o SHALL pulse, and seq_o SHALL increment.
REQ-026 From LATCH in continuous mode, the FSM SHALL return to COUNT with the timer reloaded and each live count set to 1 if its beam accepts in that cycle, else 0.
REQ-027 From LATCH in one-shot mode, the FSM SHALL return to IDLE, and triggers accepted in the LATCH cycle SHALL be discarded.
REQ-028 start_i in COUNT SHALL restart the period (counts cleared, timer reloaded) without writing a snapshot.
REQ-029 stop_i in any state SHALL force IDLE without writing a snapshot; stop_i wins over a simultaneous start_i.
REQ-030 start_i or stop_i asserted in the LATCH cycle SHALL take effect after the snapshot is written.
REQ-031 rd_dat_o SHALL be the registered value snapshot[rd_beam_i] with 1-cycle latency, and SHALL be 0 when rd_beam_i >= NBEAMS.
REQ-032 Changing mask_i mid-period SHALL affect counting from the next cycle only.
REQ-033 Snapshots SHALL hold their values until the next LATCH.

Reset
REQ-034 Reset SHALL drive: state IDLE; live counts, snapshots, holdoff counters, timer and seq_o to 0; trigger_o, done_o, busy_o and rd_dat_o to 0.
REQ-035 Reset asserted mid-period SHALL discard the period with no done_o pulse.

Configuration
REQ-036 Macro L1_SCALER_SATURATE_EN.
- Defined: live counts SHALL saturate at all-ones.
- Undefined: live counts SHALL wrap modulo 2^COUNT_WIDTH.

Structure
REQ-037 Package l1_trigger_pkg SHALL hold the state enum (IDLE/COUNT/LATCH) and the parameter defaults.
REQ-038 Per-beam holdoff, qualification and live counter SHALL be a sub-module, l1_beam_counter, instantiated NBEAMS times; timer, FSM and snapshot bank stay at top level.

Verification
(Defaults for all scenarios: NBEAMS=4, PERIOD_CLOCKS=16, holdoff_i=3.)
REQ-039 trig_i[0] held high for 16 cycles, one-shot mode -> snapshot[0]=4, done_o once, seq_o=1, FSM returns to IDLE.
REQ-040 Continuous mode, trig_i[1] pulsed in the LATCH cycle -> second-period count includes it; done_o every 17 cycles.
REQ-041 stop_i together with start_i mid-period -> IDLE, no done_o, snapshot unchanged.
REQ-042 mask_i[2]=1, trig_i[2] held high -> trigger_o[2]=0 and snapshot[2]=0.
REQ-043 COUNT_WIDTH=3, trig_i[3] high with holdoff_i=0 -> snapshot[3]=7 if L1_SCALER_SATURATE_EN is defined, else 0 (16 mod 8).
REQ-044 reset_i pulsed at cycle 8 of a period -> all outputs 0, no done_o; rd_beam_i=5 -> rd_dat_o=0.
